// File: rtl/kws_pkg.sv
// Shared types and constants for the cnn_kws_accel PSRAM access path.
package kws_pkg;

  localparam int unsigned PSRAM_ADDR_W  = 24;
  localparam int unsigned PSRAM_DATA_W  = 32;
  localparam int unsigned PSRAM_TIMEOUT = 255;

  // Requester ids double as bit positions in the req/gnt/done vectors.
  localparam logic REQ_WEIGHT = 1'b0;
  localparam logic REQ_ACT    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } psram_arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester named by prio.
module rr_arb2
  import kws_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = req;
    if (req[REQ_WEIGHT] && req[REQ_ACT]) begin
      gnt_c       = 2'b00;
      gnt_c[prio] = 1'b1;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Shares the single PSRAM command port between weight fetch and activation spill/fill,
// one outstanding transaction at a time, with a bounded wait for the controller response.
module psram_arbiter
  import kws_pkg::*;
#(
  parameter int unsigned ADDR_W  = PSRAM_ADDR_W,
  parameter int unsigned DATA_W  = PSRAM_DATA_W,
  parameter int unsigned TIMEOUT = PSRAM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              cmd_we_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [DATA_W-1:0] cmd_wdata_o,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  psram_arb_state_t state;
  logic             prio;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick_c;

  rr_arb2 u_rr_arb2 (
    .req   (req_i),
    .prio  (prio),
    .gnt_c (pick_c)
  );

  // Pulses (gnt/done/err) default low every cycle; everything else is held state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      cmd_valid_o <= 1'b0;
      cmd_we_o    <= 1'b0;
      cmd_addr_o  <= '0;
      cmd_wdata_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      gnt_o  <= '0;
      done_o <= '0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_i) begin
            gnt_o       <= pick_c;
            owner       <= pick_c[REQ_ACT];
            prio        <= pick_c[REQ_WEIGHT];
            cmd_we_o    <= pick_c[REQ_ACT] ? we_i[REQ_ACT] : we_i[REQ_WEIGHT];
            cmd_addr_o  <= pick_c[REQ_ACT] ? addr1_i : addr0_i;
            cmd_wdata_o <= pick_c[REQ_ACT] ? wdata1_i : wdata0_i;
            cmd_valid_o <= 1'b1;
            busy_o      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_valid_o && cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            cnt         <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A response on the last counted cycle still wins over the abort.
          if (rsp_valid_i) begin
            if (!cmd_we_o) rdata_o <= rsp_rdata_i;
            done_o[owner] <= 1'b1;
            state         <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            err_o         <= 1'b1;
            done_o[owner] <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Randomized scoreboard bench for psram_arbiter against a transaction-level reference model.
module tb_psram_arbiter;
  import kws_pkg::*;

  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned TB_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_i, we_i;
  logic [ADDR_W-1:0] addr0_i, addr1_i;
  logic [DATA_W-1:0] wdata0_i, wdata1_i;
  logic [1:0]        gnt_o, done_o;
  logic              err_o;
  logic [DATA_W-1:0] rdata_o;
  logic              cmd_valid_o, cmd_ready_i, cmd_we_o;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic [DATA_W-1:0] cmd_wdata_o;
  logic              rsp_valid_i;
  logic [DATA_W-1:0] rsp_rdata_i;
  logic              busy_o;

  always #5 clk = ~clk;

  psram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_we_o(cmd_we_o),
    .cmd_addr_o(cmd_addr_o), .cmd_wdata_o(cmd_wdata_o),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i), .busy_o(busy_o)
  );

  typedef struct {
    logic [1:0]        g;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } gexp_t;

  typedef struct {
    logic [1:0]        d;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  gexp_t mg;
  dexp_t md;

  int n_checks = 0;
  int n_err    = 0;

  // Requester-side view: what each requester currently wants.
  bit                pend_v[2];
  logic              pend_we[2];
  logic [ADDR_W-1:0] pend_addr[2];
  logic [DATA_W-1:0] pend_wdata[2];
  // Reference model state.
  int                m_prio;
  logic [DATA_W-1:0] m_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req();
    req_i    = {pend_v[1], pend_v[0]};
    we_i     = {pend_we[1], pend_we[0]};
    addr0_i  = pend_addr[0];
    addr1_i  = pend_addr[1];
    wdata0_i = pend_wdata[0];
    wdata1_i = pend_wdata[1];
  endtask

  task automatic set_pend(input int i, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd);
    pend_v[i]     = 1'b1;
    pend_we[i]    = we;
    pend_addr[i]  = a;
    pend_wdata[i] = wd;
  endtask

  task automatic rand_pend(input int i);
    set_pend(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
  endtask

  // Called at a negedge with the DUT idle; k = ready delay, d = response delay in WAIT cycles.
  task automatic run_txn(input int k, input int d, input logic [DATA_W-1:0] rsp_data, input bit blip);
    int          w;
    int          lat;
    int          bl;
    bit          timed_out;
    logic [1:0]  exp_g;
    gexp_t       ge;
    dexp_t       de;

    w         = (pend_v[0] && pend_v[1]) ? m_prio : (pend_v[1] ? 1 : 0);
    m_prio    = 1 - w;
    exp_g     = (w == 1) ? 2'b10 : 2'b01;
    timed_out = (d > int'(TB_TIMEOUT));
    if (!pend_we[w] && !timed_out) m_rdata = rsp_data;
    ge.g = exp_g; ge.we = pend_we[w]; ge.addr = pend_addr[w]; ge.wdata = pend_wdata[w];
    de.d = exp_g; de.err = timed_out; de.rdata = m_rdata;
    gq.push_back(ge);
    dq.push_back(de);
    drive_req();

    @(negedge clk);
    chk("grant_latency", gnt_o, exp_g);
    chk("busy_on_grant", busy_o, 1);
    pend_v[w] = 1'b0;
    drive_req();

    for (int i = 0; i <= k; i++) begin
      if (i > 0) @(negedge clk);
      cmd_ready_i = (i == k);
      chk("issue_valid", cmd_valid_o, 1);
      chk("issue_we", cmd_we_o, ge.we);
      chk("issue_addr", cmd_addr_o, ge.addr);
      chk("issue_wdata", cmd_wdata_o, ge.wdata);
    end

    @(negedge clk);
    cmd_ready_i = 1'b0;
    chk("wait_valid_low", cmd_valid_o, 0);
    rsp_valid_i = (d == 0);
    rsp_rdata_i = (d == 0) ? rsp_data : DATA_W'($urandom);
    bl = -1;
    if (blip && !(pend_v[0] && pend_v[1])) begin
      bl = pend_v[0] ? 1 : 0;
      req_i[bl] = 1'b1;
    end

    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      drive_req();
      if (done_o != 2'b00 || lat > int'(TB_TIMEOUT) + 5) break;
      rsp_valid_i = (lat == d);
      rsp_rdata_i = (lat == d) ? rsp_data : DATA_W'($urandom);
    end
    chk("done_latency", lat, (timed_out ? int'(TB_TIMEOUT) : d) + 1);
    chk("busy_in_resp", busy_o, 1);
    // A late response lands while the DUT is in RESP and must be ignored.
    rsp_valid_i = timed_out;
    rsp_rdata_i = DATA_W'($urandom);

    @(negedge clk);
    rsp_valid_i = 1'b0;
    chk("busy_back_idle", busy_o, 0);
    chk("rdata_hold", rdata_o, m_rdata);
  endtask

  task automatic drain();
    while (pend_v[0] || pend_v[1])
      run_txn($urandom_range(0, 2), $urandom_range(0, 3), DATA_W'($urandom), 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, gnt_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_cmd_valid"}, cmd_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_cmd_we"}, cmd_we_o, 0);
    chk({tag, "_cmd_addr"}, cmd_addr_o, 0);
    chk({tag, "_cmd_wdata"}, cmd_wdata_o, 0);
    chk({tag, "_rdata"}, rdata_o, 0);
  endtask

  // Monitor: every grant or completion the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt_o != 2'b00) begin
        if (gq.size() == 0) chk("gnt_unexpected", gnt_o, 0);
        else begin
          mg = gq.pop_front();
          chk("sb_gnt", gnt_o, mg.g);
          chk("sb_cmd_we", cmd_we_o, mg.we);
          chk("sb_cmd_addr", cmd_addr_o, mg.addr);
          chk("sb_cmd_wdata", cmd_wdata_o, mg.wdata);
        end
      end
      if (done_o != 2'b00) begin
        if (dq.size() == 0) chk("done_unexpected", done_o, 0);
        else begin
          md = dq.pop_front();
          chk("sb_done", done_o, md.d);
          chk("sb_err", err_o, md.err);
          chk("sb_rdata", rdata_o, md.rdata);
        end
      end else begin
        chk("err_without_done", err_o, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_rdata_i = '0;
    for (int i = 0; i < 2; i++) set_pend(i, 1'b0, '0, '0);
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    drive_req();
    m_prio = 0; m_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single read from the weight requester.
    set_pend(0, 1'b0, 24'h000100, 32'h0);
    run_txn(0, 2, 32'hDEADBEEF, 1'b0);

    // Contention: both requesters keep requesting, grants must alternate.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 2; i++) if (!pend_v[i]) rand_pend(i);
      run_txn($urandom_range(0, 2), $urandom_range(0, 3), DATA_W'($urandom), 1'b0);
    end
    drain();

    // Backpressured write from requester 1, with a one-cycle withdrawn request from requester 0.
    set_pend(1, 1'b1, 24'h00FFFC, 32'h12345678);
    run_txn(5, 1, DATA_W'($urandom), 1'b1);

    // Timeout followed by a normal transaction.
    set_pend(0, 1'b0, 24'h000200, 32'h0);
    run_txn(0, int'(TB_TIMEOUT) + 1, 32'hBAD0BAD0, 1'b0);
    set_pend(1, 1'b0, 24'h000300, 32'h0);
    run_txn(1, 1, 32'hCAFEF00D, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) if (!pend_v[i] && $urandom_range(0, 1) == 1) rand_pend(i);
      if (!pend_v[0] && !pend_v[1]) rand_pend($urandom_range(0, 1));
      run_txn($urandom_range(0, 3), $urandom_range(0, int'(TB_TIMEOUT) + 1), DATA_W'($urandom),
              ($urandom_range(0, 3) == 0));
    end
    drain();

    // Reset during WAIT: in-flight transaction dropped, prio returns to requester 0.
    set_pend(0, 1'b0, 24'h000ABC, 32'h0);
    mg.g = 2'b01; mg.we = 1'b0; mg.addr = 24'h000ABC; mg.wdata = 32'h0;
    gq.push_back(mg);
    m_prio = 1;
    drive_req();
    @(negedge clk);
    chk("rst_seq_grant", gnt_o, 2'b01);
    pend_v[0] = 1'b0;
    drive_req();
    cmd_ready_i = 1'b1;
    @(negedge clk);
    cmd_ready_i = 1'b0;
    chk("rst_seq_in_wait", busy_o, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    m_prio = 0; m_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("held_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_no_done", done_o, 0);
    rand_pend(0);
    rand_pend(1);
    run_txn(0, 0, DATA_W'($urandom), 1'b0);
    drain();
    chk("gq_empty", gq.size(), 0);
    chk("dq_empty", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
